// File: rtl/top_decryption_core.sv
// PRESENT-80 iterative decryption core: one round per clock.
// Optional macro DECRYPT_KEY_CACHE_EN caches the expanded K32 of the last key.
module top_decryption_core (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_wr,
    input  logic [63:0] in_data,
    input  logic [79:0] key,
    output logic [63:0] out_data,
    output logic        o_wr,
    output logic        busy
);

    typedef enum logic [1:0] {
        IDLE,
        KEYEXP,
        DECRYPT,
        DONE
    } state_t;

    state_t      state;
    logic [63:0] data;
    logic [79:0] k;
    logic [4:0]  cnt;

`ifdef DECRYPT_KEY_CACHE_EN
    logic [79:0] cache_key;
    logic [79:0] cache_k32;
    logic        cache_valid;
`endif

    function automatic logic [3:0] sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'hC;
            4'h1: y = 4'h5;
            4'h2: y = 4'h6;
            4'h3: y = 4'hB;
            4'h4: y = 4'h9;
            4'h5: y = 4'h0;
            4'h6: y = 4'hA;
            4'h7: y = 4'hD;
            4'h8: y = 4'h3;
            4'h9: y = 4'hE;
            4'hA: y = 4'hF;
            4'hB: y = 4'h8;
            4'hC: y = 4'h4;
            4'hD: y = 4'h7;
            4'hE: y = 4'h1;
            default: y = 4'h2;
        endcase
        return y;
    endfunction

    function automatic logic [3:0] inv_sbox(input logic [3:0] x);
        logic [3:0] y;
        case (x)
            4'h0: y = 4'h5;
            4'h1: y = 4'hE;
            4'h2: y = 4'hF;
            4'h3: y = 4'h8;
            4'h4: y = 4'hC;
            4'h5: y = 4'h1;
            4'h6: y = 4'h2;
            4'h7: y = 4'hD;
            4'h8: y = 4'hB;
            4'h9: y = 4'h4;
            4'hA: y = 4'h6;
            4'hB: y = 4'h3;
            4'hC: y = 4'h0;
            4'hD: y = 4'h7;
            4'hE: y = 4'h9;
            default: y = 4'hA;
        endcase
        return y;
    endfunction

    function automatic logic [63:0] inv_perm(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int j = 0; j < 63; j++) begin
            r[(4 * j) % 63] = s[j];
        end
        r[63] = s[63];
        return r;
    endfunction

    function automatic logic [63:0] inv_slayer(input logic [63:0] s);
        logic [63:0] r;
        r = '0;
        for (int n = 0; n < 16; n++) begin
            r[4*n +: 4] = inv_sbox(s[4*n +: 4]);
        end
        return r;
    endfunction

    function automatic logic [79:0] key_fwd(
        input logic [79:0] kin,
        input logic [4:0]  rc
    );
        logic [79:0] t;
        t = {kin[18:0], kin[79:19]};
        t[79:76] = sbox(t[79:76]);
        t[19:15] = t[19:15] ^ rc;
        return t;
    endfunction

    // exact inverse of key_fwd: undo xor, undo S-box, rotate right 61
    function automatic logic [79:0] key_inv(
        input logic [79:0] kin,
        input logic [4:0]  rc
    );
        logic [79:0] t;
        t = kin;
        t[19:15] = t[19:15] ^ rc;
        t[79:76] = inv_sbox(t[79:76]);
        return {t[60:0], t[79:61]};
    endfunction

    logic [79:0] k_next_fwd;
    logic [79:0] k_next_inv;
    logic [63:0] data_next;

    assign k_next_fwd = key_fwd(k, cnt);
    assign k_next_inv = key_inv(k, cnt);
    assign data_next  = inv_slayer(inv_perm(data ^ k[79:16]));

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state    <= IDLE;
            data     <= '0;
            k        <= '0;
            cnt      <= '0;
            out_data <= '0;
            o_wr     <= 1'b0;
            busy     <= 1'b0;
`ifdef DECRYPT_KEY_CACHE_EN
            cache_key   <= '0;
            cache_k32   <= '0;
            cache_valid <= 1'b0;
`endif
        end else begin
            o_wr <= 1'b0;
            unique case (state)
                IDLE: begin
                    busy <= in_wr;
                    if (in_wr) begin
                        data <= in_data;
`ifdef DECRYPT_KEY_CACHE_EN
                        if (cache_valid && cache_key == key) begin
                            k     <= cache_k32;
                            cnt   <= 5'd31;
                            state <= DECRYPT;
                        end else begin
                            k           <= key;
                            cnt         <= 5'd1;
                            state       <= KEYEXP;
                            cache_key   <= key;
                            cache_valid <= 1'b0;
                        end
`else
                        k     <= key;
                        cnt   <= 5'd1;
                        state <= KEYEXP;
`endif
                    end
                end
                KEYEXP: begin
                    k <= k_next_fwd;
                    if (cnt == 5'd31) begin
                        state <= DECRYPT;
`ifdef DECRYPT_KEY_CACHE_EN
                        cache_k32   <= k_next_fwd;
                        cache_valid <= 1'b1;
`endif
                    end else begin
                        cnt <= cnt + 5'd1;
                    end
                end
                DECRYPT: begin
                    data <= data_next;
                    k    <= k_next_inv;
                    cnt  <= cnt - 5'd1;
                    if (cnt == 5'd1) begin
                        state <= DONE;
                    end
                end
                DONE: begin
                    out_data <= data ^ k[79:16];
                    o_wr     <= 1'b1;
                    state    <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_top_decryption_core.sv
// Self-checking bench for top_decryption_core (KATs, random, corners).
module tb_top_decryption_core;

    logic        clk;
    logic        rst_n;
    logic        in_wr;
    logic [63:0] in_data;
    logic [79:0] key;
    logic [63:0] out_data;
    logic        o_wr;
    logic        busy;

    int total = 0;
    int bad   = 0;

    top_decryption_core dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .in_wr    (in_wr),
        .in_data  (in_data),
        .key      (key),
        .out_data (out_data),
        .o_wr     (o_wr),
        .busy     (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    localparam logic [3:0] SB [16] = '{
        4'hC, 4'h5, 4'h6, 4'hB, 4'h9, 4'h0, 4'hA, 4'hD,
        4'h3, 4'hE, 4'hF, 4'h8, 4'h4, 4'h7, 4'h1, 4'h2
    };

    localparam logic [79:0] KF = {80{1'b1}};
    localparam logic [63:0] DF = {64{1'b1}};

    // forward PRESENT-80 encryption, used as the oracle for decryption
    function automatic logic [63:0] enc(
        input logic [63:0] pt,
        input logic [79:0] kk
    );
        logic [79:0] r;
        logic [63:0] s;
        logic [63:0] t;
        r = kk;
        s = pt;
        for (int i = 1; i <= 31; i++) begin
            s = s ^ r[79:16];
            for (int n = 0; n < 16; n++) s[4*n +: 4] = SB[s[4*n +: 4]];
            t = '0;
            for (int b = 0; b < 63; b++) t[(16 * b) % 63] = s[b];
            t[63] = s[63];
            s = t;
            r = {r[18:0], r[79:19]};
            r[79:76] = SB[r[79:76]];
            r[19:15] = r[19:15] ^ 5'(i);
        end
        return s ^ r[79:16];
    endfunction

    // model of the key cache: which key would hit
    logic [79:0] mc_key = '0;
    logic        mc_valid = 1'b0;

    function automatic int exp_lat(input logic [79:0] kk);
        int l;
        l = 63;
`ifdef DECRYPT_KEY_CACHE_EN
        if (mc_valid && mc_key == kk) l = 32;
`endif
        mc_key   = kk;
        mc_valid = 1'b1;
        return l;
    endfunction

    task automatic chk(input string nm, input logic [79:0] act,
                       input logic [79:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h", nm, act, exp);
        end
    endtask

    task automatic start(input logic [79:0] kk, input logic [63:0] ct);
        @(negedge clk);
        in_wr   = 1'b1;
        key     = kk;
        in_data = ct;
        @(negedge clk);
        in_wr = 1'b0;
    endtask

    task automatic wait_done(input int from, output int lat);
        lat = 0;
        for (int c = from; c <= 100; c++) begin
            @(negedge clk);
            if (o_wr) begin
                lat = c;
                break;
            end
        end
    endtask

    task automatic count_pulses(input int n, output int p);
        p = 0;
        for (int c = 0; c < n; c++) begin
            @(negedge clk);
            if (o_wr) p++;
        end
    endtask

    task automatic run(input string nm, input logic [79:0] kk,
                       input logic [63:0] ct, input logic [63:0] pt);
        int lat;
        int el;
        el = exp_lat(kk);
        start(kk, ct);
        chk({nm, "_busy_hi"}, 80'(busy), 80'(1));
        wait_done(1, lat);
        chk({nm, "_lat"}, 80'(lat), 80'(el));
        chk({nm, "_data"}, 80'(out_data), 80'(pt));
        chk({nm, "_busy_o"}, 80'(busy), 80'(1));
        @(negedge clk);
        chk({nm, "_owr_lo"}, 80'(o_wr), 80'(0));
        chk({nm, "_busy_lo"}, 80'(busy), 80'(0));
        chk({nm, "_hold"}, 80'(out_data), 80'(pt));
    endtask

    typedef struct {
        logic [79:0] k;
        logic [63:0] ct;
        logic [63:0] pt;
    } vec_t;

    vec_t tbl [4];

    initial begin
        int lat;
        int p;
        logic [79:0] rk;
        logic [63:0] rp;

        tbl[0] = '{k: '0, ct: 64'h5579C1387B228445, pt: '0};
        tbl[1] = '{k: '0, ct: 64'hA112FFC72F68417B, pt: DF};
        tbl[2] = '{k: KF, ct: 64'h3333DCD3213210D2, pt: DF};
        tbl[3] = '{k: KF, ct: 64'hE72C46C0F5945049, pt: '0};

        rst_n   = 1'b0;
        in_wr   = 1'b0;
        in_data = '0;
        key     = '0;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        chk("rst_out", 80'(out_data), 80'(0));
        chk("rst_owr", 80'(o_wr), 80'(0));
        chk("rst_busy", 80'(busy), 80'(0));
        count_pulses(10, p);
        chk("idle_no_owr", 80'(p), 80'(0));

        for (int i = 0; i < 4; i++) begin
            run($sformatf("kat%0d", i), tbl[i].k, tbl[i].ct, tbl[i].pt);
        end

        // second strobe mid-operation must be ignored
        begin
            int el;
            el = exp_lat(KF);
            start(KF, 64'hE72C46C0F5945049);
            repeat (9) @(negedge clk);
            in_wr   = 1'b1;
            in_data = 64'h0123456789ABCDEF;
            key     = 80'h1234;
            @(negedge clk);
            in_wr = 1'b0;
            wait_done(11, lat);
            chk("busy_prot_lat", 80'(lat), 80'(el));
            chk("busy_prot_data", 80'(out_data), 80'(0));
            count_pulses(80, p);
            chk("busy_prot_single", 80'(p), 80'(0));
        end

        // reset at cycle 40 discards the block
        start(80'h0, 64'h5579C1387B228445);
        repeat (39) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n    = 1'b1;
        mc_valid = 1'b0;
        chk("midrst_busy", 80'(busy), 80'(0));
        chk("midrst_out", 80'(out_data), 80'(0));
        count_pulses(80, p);
        chk("midrst_no_owr", 80'(p), 80'(0));
        run("after_rst", '0, 64'hA112FFC72F68417B, DF);

        // strobe coincident with reset is ignored
        @(negedge clk);
        rst_n   = 1'b0;
        in_wr   = 1'b1;
        key     = KF;
        in_data = 64'h3333DCD3213210D2;
        @(negedge clk);
        rst_n    = 1'b1;
        in_wr    = 1'b0;
        mc_valid = 1'b0;
        chk("rst_wr_busy", 80'(busy), 80'(0));
        count_pulses(70, p);
        chk("rst_wr_no_owr", 80'(p), 80'(0));

        // random blocks, odd ones reuse the previous key
        rk = '0;
        for (int i = 0; i < 8; i++) begin
            if (i % 2 == 0) rk = {16'($urandom), $urandom, $urandom};
            rp = {$urandom, $urandom};
            run($sformatf("rnd%0d", i), rk, enc(rp, rk), rp);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
